moesif_snoop_responder: RTL and testbench

MOESIF_SNOOP_RESPONDER -- requirements
Module: moesif_snoop_responder

---
 rtl/moesif_snoop_responder.sv | 213 +++++++++++++++++++++
 tb/tb_moesif_snoop_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moesif_snoop_responder.sv
// Snoop-side responder for a MOESIF cache: looks up a snooped line, streams it out when this
// cache owns the data, then downgrades/invalidates. Line codes: I=0 M=1 O=2 E=3 S=4 F=5.
module moesif_snoop_responder #(
  parameter int unsigned ADDRESS_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned TAG_WIDTH          = 16,
  parameter int unsigned INDEX_WIDTH        = 8,
  parameter int unsigned OFFSET_WIDTH       = 8,
  parameter int unsigned SET_ASSOCIATIVITY  = 4,
  parameter int unsigned NUMBER_OF_CACHES   = 8,
  parameter int unsigned CACHE_NUMBER_WIDTH = $clog2(NUMBER_OF_CACHES),
  parameter int unsigned CACHE_NUMBER       = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          busRequest,
  input  logic [1:0]                    busCommand,
  input  logic [ADDRESS_WIDTH-1:0]      busAddress,
  input  logic [CACHE_NUMBER_WIDTH-1:0] busCacheNumber,
  output logic                          snoopHit,
  output logic [DATA_WIDTH-1:0]         snoopData,
  output logic                          snoopDataValid,
  input  logic                          snoopDataReady,
  output logic                          snoopDone,
  output logic                          arbiterRequest,
  input  logic                          arbiterGrant,
  output logic [TAG_WIDTH-1:0]          cacheTag,
  output logic [INDEX_WIDTH-1:0]        cacheIndex,
  output logic [OFFSET_WIDTH-1:0]       cacheOffset,
  input  logic                          cacheHit,
  input  logic [2:0]                    cacheState,
  input  logic [DATA_WIDTH-1:0]         cacheDataIn,
  output logic [2:0]                    cacheStateOut,
  output logic                          cacheStateWrite
);

  if (TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH != ADDRESS_WIDTH) begin : g_bad_address_split
    $error("tag, index and offset widths must add up to the address width");
  end
  if (SET_ASSOCIATIVITY < 1 || CACHE_NUMBER >= NUMBER_OF_CACHES) begin : g_bad_geometry
    $error("invalid set associativity or own cache number");
  end

  localparam logic [2:0] LINE_I = 3'd0;
  localparam logic [2:0] LINE_M = 3'd1;
  localparam logic [2:0] LINE_O = 3'd2;
  localparam logic [2:0] LINE_E = 3'd3;
  localparam logic [2:0] LINE_S = 3'd4;
  localparam logic [2:0] LINE_F = 3'd5;

  localparam logic [1:0] CMD_READ       = 2'd1;
  localparam logic [1:0] CMD_INVALIDATE = 2'd2;

  localparam logic [OFFSET_WIDTH-1:0] LAST_OFFSET = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARBITRATE,
    ST_LOOKUP,
    ST_SUPPLY,
    ST_UPDATE,
    ST_DONE
  } state_t;

  state_t                  state_q, state_n;
  logic                    inv_q, inv_n;
  logic [TAG_WIDTH-1:0]    tag_q, tag_n;
  logic [INDEX_WIDTH-1:0]  index_q, index_n;
  logic                    hit_q, hit_n;
  logic [2:0]              line_q, line_n;
  logic [OFFSET_WIDTH-1:0] offset_n;

  logic                    snoop_hit_n, valid_n, done_n, arb_n, write_n, drive_addr;
  logic [TAG_WIDTH-1:0]    cache_tag_n;
  logic [INDEX_WIDTH-1:0]  cache_index_n;
  logic [2:0]              state_out_n;
  logic                    lookup_hit;
  logic                    unused_offset_bits;

  // The bus offset is ignored: a supplied line always streams from word 0.
  assign unused_offset_bits = ^busAddress[OFFSET_WIDTH-1:0];
  assign lookup_hit         = cacheHit && (cacheState != LINE_I);

  // Word data comes straight from the cache read port so it stays aligned with cacheOffset.
  assign snoopData = snoopDataValid ? cacheDataIn : '0;

  function automatic logic [2:0] line_after(input logic inv, input logic [2:0] cur);
    logic [2:0] nxt;
    nxt = cur;
    if (inv) begin
      nxt = LINE_I;
    end else begin
      case (cur)
        LINE_M, LINE_O: nxt = LINE_O;
        LINE_E, LINE_F: nxt = LINE_S;
        default:        nxt = cur;
      endcase
    end
    return nxt;
  endfunction

  // Only the data-carrying states answer with the line; a shared copy stays silent.
  function automatic logic must_supply(input logic [2:0] cur);
    return (cur == LINE_M) || (cur == LINE_O) || (cur == LINE_E) || (cur == LINE_F);
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state_q;
    inv_n    = inv_q;
    tag_n    = tag_q;
    index_n  = index_q;
    hit_n    = hit_q;
    line_n   = line_q;
    offset_n = cacheOffset;

    case (state_q)
      ST_IDLE: begin
        if (busRequest) begin
          hit_n = 1'b0;
          if ((busCacheNumber == CACHE_NUMBER_WIDTH'(CACHE_NUMBER)) ||
              !((busCommand == CMD_READ) || (busCommand == CMD_INVALIDATE))) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_ARBITRATE;
            inv_n   = (busCommand == CMD_INVALIDATE);
            tag_n   = busAddress[ADDRESS_WIDTH-1 -: TAG_WIDTH];
            index_n = busAddress[OFFSET_WIDTH +: INDEX_WIDTH];
          end
        end
      end
      ST_ARBITRATE: begin
        if (arbiterGrant) state_n = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        hit_n  = lookup_hit;
        line_n = cacheState;
        if (!lookup_hit) begin
          state_n = ST_DONE;
        end else if (must_supply(cacheState)) begin
          state_n = ST_SUPPLY;
        end else if (line_after(inv_q, cacheState) != cacheState) begin
          state_n = ST_UPDATE;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_SUPPLY: begin
        if (snoopDataValid && snoopDataReady) begin
          if (cacheOffset == LAST_OFFSET) begin
            state_n = (line_after(inv_q, line_q) != line_q) ? ST_UPDATE : ST_DONE;
          end else begin
            offset_n = cacheOffset + OFFSET_WIDTH'(1);
          end
        end
      end
      ST_UPDATE: state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    if (state_n != ST_SUPPLY) offset_n = '0;

    drive_addr    = (state_n == ST_LOOKUP) || (state_n == ST_SUPPLY) || (state_n == ST_UPDATE);
    cache_tag_n   = drive_addr ? tag_n : '0;
    cache_index_n = drive_addr ? index_n : '0;
    valid_n       = (state_n == ST_SUPPLY);
    done_n        = (state_n == ST_DONE);
    snoop_hit_n   = done_n && hit_n;
    write_n       = (state_n == ST_UPDATE);
    state_out_n   = write_n ? line_after(inv_n, line_n) : LINE_I;
    // Request is held through DONE, but never raised on the local short-circuit path.
    arb_n         = (state_n == ST_ARBITRATE) || drive_addr || (done_n && arbiterRequest);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      inv_q           <= 1'b0;
      tag_q           <= '0;
      index_q         <= '0;
      hit_q           <= 1'b0;
      line_q          <= LINE_I;
      snoopHit        <= 1'b0;
      snoopDataValid  <= 1'b0;
      snoopDone       <= 1'b0;
      arbiterRequest  <= 1'b0;
      cacheTag        <= '0;
      cacheIndex      <= '0;
      cacheOffset     <= '0;
      cacheStateOut   <= LINE_I;
      cacheStateWrite <= 1'b0;
    end else begin
      state_q         <= state_n;
      inv_q           <= inv_n;
      tag_q           <= tag_n;
      index_q         <= index_n;
      hit_q           <= hit_n;
      line_q          <= line_n;
      snoopHit        <= snoop_hit_n;
      snoopDataValid  <= valid_n;
      snoopDone       <= done_n;
      arbiterRequest  <= arb_n;
      cacheTag        <= cache_tag_n;
      cacheIndex      <= cache_index_n;
      cacheOffset     <= offset_n;
      cacheStateOut   <= state_out_n;
      cacheStateWrite <= write_n;
    end
  end

endmodule

// File: tb/tb_moesif_snoop_responder.sv
// Scoreboard bench for moesif_snoop_responder: directed snoops push expected words, state
// writes and completions; a negedge monitor pops and compares them as the DUT produces them.
module tb_moesif_snoop_responder;

  localparam int unsigned TW = 22;
  localparam int unsigned IW = 8;
  localparam int unsigned OW = 2;
  localparam int unsigned CW = 3;

  localparam logic [2:0] L_I = 3'd0, L_M = 3'd1, L_O = 3'd2, L_E = 3'd3, L_S = 3'd4, L_F = 3'd5;
  localparam logic [1:0] C_NONE = 2'd0, C_READ = 2'd1, C_INV = 2'd2, C_RSVD = 2'd3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          busRequest = 1'b0;
  logic [1:0]    busCommand = 2'd0;
  logic [31:0]   busAddress = '0;
  logic [CW-1:0] busCacheNumber = '0;
  logic          snoopHit, snoopDataValid, snoopDone, arbiterRequest, arbiterGrant;
  logic [31:0]   snoopData, cacheDataIn;
  logic          snoopDataReady = 1'b1;
  logic [TW-1:0] cacheTag;
  logic [IW-1:0] cacheIndex;
  logic [OW-1:0] cacheOffset;
  logic          cacheHit, cacheStateWrite;
  logic [2:0]    cacheState, cacheStateOut;

  moesif_snoop_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW),
    .SET_ASSOCIATIVITY(4), .NUMBER_OF_CACHES(8), .CACHE_NUMBER(0)
  ) dut (
    .clock(clock), .reset(reset), .busRequest(busRequest), .busCommand(busCommand),
    .busAddress(busAddress), .busCacheNumber(busCacheNumber), .snoopHit(snoopHit),
    .snoopData(snoopData), .snoopDataValid(snoopDataValid), .snoopDataReady(snoopDataReady),
    .snoopDone(snoopDone), .arbiterRequest(arbiterRequest), .arbiterGrant(arbiterGrant),
    .cacheTag(cacheTag), .cacheIndex(cacheIndex), .cacheOffset(cacheOffset),
    .cacheHit(cacheHit), .cacheState(cacheState), .cacheDataIn(cacheDataIn),
    .cacheStateOut(cacheStateOut), .cacheStateWrite(cacheStateWrite)
  );

  always #5 clock = ~clock;

  // Cache and arbiter models.
  logic          m_hit = 1'b0;
  logic [TW-1:0] m_tag = '0;
  logic [IW-1:0] m_index = '0;
  logic [2:0]    m_state = 3'd0;
  int            grant_delay = 0;
  int            req_cnt = 0;
  logic          ready_toggle = 1'b0;
  int            cyc = 0;
  int            arb_cnt = 0;

  assign cacheHit     = m_hit && (cacheTag == m_tag) && (cacheIndex == m_index);
  assign cacheState   = m_state;
  assign cacheDataIn  = {cacheTag[13:0], cacheIndex, 8'h00, cacheOffset};
  assign arbiterGrant = arbiterRequest && (req_cnt >= grant_delay);

  always @(posedge clock) begin
    cyc     <= cyc + 1;
    req_cnt <= arbiterRequest ? req_cnt + 1 : 0;
  end

  always @(posedge clock) begin
    #1;
    if (ready_toggle) snoopDataReady = ~snoopDataReady;
    else snoopDataReady = 1'b1;
  end

  always @(negedge clock) if (arbiterRequest) arb_cnt++;

  // Scoreboard.
  typedef struct { logic hit; int cyc; } done_t;
  logic [31:0] exp_word_q[$];
  logic [32:0] exp_write_q[$];
  done_t       exp_done_q[$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    checks++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  logic        stall_prev = 1'b0;
  logic [31:0] stall_data;
  logic [OW-1:0] stall_off;

  // Monitor: compare every DUT-presented event against the head of its queue.
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(snoopDataValid), 64'd1);
        check("stall_data", 64'(snoopData), 64'(stall_data));
        check("stall_offset", 64'(cacheOffset), 64'(stall_off));
      end
      stall_prev = snoopDataValid && !snoopDataReady;
      stall_data = snoopData;
      stall_off  = cacheOffset;

      if (snoopDataValid && snoopDataReady) begin
        if (exp_word_q.size() == 0) fail("unexpected_word", 64'(snoopData));
        else begin
          logic [31:0] w;
          w = exp_word_q.pop_front();
          check("word_data", 64'(snoopData), 64'(w));
          check("word_offset", 64'(cacheOffset), 64'(w[1:0]));
        end
      end

      if (cacheStateWrite) begin
        if (exp_write_q.size() == 0) fail("unexpected_state_write", 64'(cacheStateOut));
        else check("state_write", 64'({cacheStateOut, cacheTag, cacheIndex}),
                   64'(exp_write_q.pop_front()));
      end

      if (snoopDone) begin
        if (exp_done_q.size() == 0) fail("unexpected_done", 64'(snoopHit));
        else begin
          done_t d;
          d = exp_done_q.pop_front();
          check("done_hit", 64'(snoopHit), 64'(d.hit));
          if (d.cyc >= 0) check("done_latency", 64'(cyc), 64'(d.cyc));
        end
      end else if (snoopHit) begin
        fail("hit_without_done", 64'(snoopHit));
      end
    end
  end

  task automatic push_words(input logic [TW-1:0] tag, input logic [IW-1:0] idx, input int n);
    for (int o = 0; o < n; o++) exp_word_q.push_back({tag[13:0], idx, 8'h00, 2'(o)});
  endtask

  task automatic push_write(input logic [2:0] st, input logic [TW-1:0] tag, input logic [IW-1:0] idx);
    exp_write_q.push_back({st, tag, idx});
  endtask

  task automatic push_done(input logic hit, input int lat);
    done_t d;
    d.hit = hit;
    d.cyc = (lat < 0) ? -1 : cyc + lat;
    exp_done_q.push_back(d);
  endtask

  task automatic set_line(input logic hit, input logic [2:0] st, input logic [TW-1:0] tag,
                          input logic [IW-1:0] idx);
    m_hit = hit; m_state = st; m_tag = tag; m_index = idx;
  endtask

  int issue_cyc;

  // Present one snoop for a single cycle, then scramble the bus to show it is not re-read.
  task automatic issue(input logic [1:0] cmd, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                       input logic [CW-1:0] cn);
    busCommand     = cmd;
    busAddress     = {tag, idx, 2'b11};
    busCacheNumber = cn;
    busRequest     = 1'b1;
    issue_cyc      = cyc;
    @(negedge clock);
    busRequest     = 1'b0;
    busCommand     = C_NONE;
    busAddress     = '1;
    busCacheNumber = '0;
  endtask

  task automatic finish_txn(input string name);
    int n;
    n = 0;
    while (exp_done_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) fail({name, "_done_timeout"}, 64'(exp_done_q.size()));
    @(negedge clock);
    check({name, "_words_left"}, 64'(exp_word_q.size()), 64'd0);
    check({name, "_writes_left"}, 64'(exp_write_q.size()), 64'd0);
    exp_word_q.delete();
    exp_write_q.delete();
    exp_done_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_hit"}, 64'(snoopHit), 64'd0);
    check({name, "_valid"}, 64'(snoopDataValid), 64'd0);
    check({name, "_done"}, 64'(snoopDone), 64'd0);
    check({name, "_arb"}, 64'(arbiterRequest), 64'd0);
    check({name, "_write"}, 64'(cacheStateWrite), 64'd0);
    check({name, "_data"}, 64'(snoopData), 64'd0);
    check({name, "_addr"}, 64'({cacheTag, cacheIndex, cacheOffset}), 64'd0);
    check({name, "_state_out"}, 64'(cacheStateOut), 64'd0);
  endtask

  initial begin
    int arb_before;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // BUS_READ on M: four words, M->O, 8 cycles.
    set_line(1'b1, L_M, 22'h2ABCD, 8'h3C);
    push_words(22'h2ABCD, 8'h3C, 4);
    push_write(L_O, 22'h2ABCD, 8'h3C);
    push_done(1'b1, 8);
    issue(C_READ, 22'h2ABCD, 8'h3C, 3'd5);
    finish_txn("read_m");

    // BUS_INVALIDATE on S: no data, S->I, 4 cycles.
    set_line(1'b1, L_S, 22'h01234, 8'h81);
    push_write(L_I, 22'h01234, 8'h81);
    push_done(1'b1, 4);
    issue(C_INV, 22'h01234, 8'h81, 3'd2);
    finish_txn("inv_s");

    // Own request, NONE and reserved commands: done next cycle, no arbitration.
    arb_before = arb_cnt;
    set_line(1'b1, L_M, 22'h00777, 8'h07);
    push_done(1'b0, 1);
    issue(C_READ, 22'h00777, 8'h07, 3'd0);
    finish_txn("own");
    push_done(1'b0, 1);
    issue(C_NONE, 22'h00777, 8'h07, 3'd4);
    finish_txn("cmd_none");
    push_done(1'b0, 1);
    issue(C_RSVD, 22'h00777, 8'h07, 3'd4);
    finish_txn("cmd_rsvd");
    check("short_path_arb_cycles", 64'(arb_cnt - arb_before), 64'd0);

    // BUS_READ on E with toggling ready: stalls hold data, E->S.
    set_line(1'b1, L_E, 22'h3F00F, 8'hA5);
    push_words(22'h3F00F, 8'hA5, 4);
    push_write(L_S, 22'h3F00F, 8'hA5);
    push_done(1'b1, -1);
    ready_toggle = 1'b1;
    issue(C_READ, 22'h3F00F, 8'hA5, 3'd1);
    finish_txn("read_e_stall");
    ready_toggle = 1'b0;
    repeat (2) @(negedge clock);

    // Miss with grant three cycles late.
    set_line(1'b0, L_M, 22'h11111, 8'h11);
    grant_delay = 3;
    push_done(1'b0, 6);
    issue(C_READ, 22'h11111, 8'h11, 3'd6);
    finish_txn("miss_late_grant");
    grant_delay = 0;

    // BUS_READ on O: supplies, no state write, done right after the last word.
    set_line(1'b1, L_O, 22'h0BEEF, 8'h5A);
    push_words(22'h0BEEF, 8'h5A, 4);
    push_done(1'b1, 7);
    issue(C_READ, 22'h0BEEF, 8'h5A, 3'd3);
    finish_txn("read_o");

    // BUS_READ on S: no supply, no write, 3 cycles.
    set_line(1'b1, L_S, 22'h02020, 8'hC3);
    push_done(1'b1, 3);
    issue(C_READ, 22'h02020, 8'hC3, 3'd7);
    finish_txn("read_s");

    // BUS_INVALIDATE on F: supplies, F->I.
    set_line(1'b1, L_F, 22'h1C0DE, 8'h99);
    push_words(22'h1C0DE, 8'h99, 4);
    push_write(L_I, 22'h1C0DE, 8'h99);
    push_done(1'b1, 8);
    issue(C_INV, 22'h1C0DE, 8'h99, 3'd4);
    finish_txn("inv_f");

    // Reset while the second word of an M supply is being accepted.
    set_line(1'b1, L_M, 22'h0ACED, 8'h42);
    push_words(22'h0ACED, 8'h42, 2);
    issue(C_READ, 22'h0ACED, 8'h42, 3'd2);
    while (cyc < issue_cyc + 4) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("mid_supply_reset");
    check("mid_reset_words_left", 64'(exp_word_q.size()), 64'd0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("post_reset_idle_done", 64'(snoopDone), 64'd0);
    exp_word_q.delete();

    // A fresh request is served normally after the abort.
    set_line(1'b1, L_S, 22'h00042, 8'h24);
    push_write(L_I, 22'h00042, 8'h24);
    push_done(1'b1, 4);
    issue(C_INV, 22'h00042, 8'h24, 3'd1);
    finish_txn("after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
